// File: rtl/hsv2rgb_pipe.sv
// hsv2rgb_pipe: three-stage HSV->RGB converter with valid/ready flow control.
// Stage 1 finds the hue sector and fraction, stage 2 forms the P/Q/T products,
// stage 3 selects and packs the channels. There is no divider: the 1/60-degree
// hue scaling is an H*6 with the sector taken from the bits above DW.
module hsv2rgb_pipe #(
  parameter int unsigned DW    = 8,
  parameter int unsigned TAG_W = 19,
  parameter int unsigned ORDER = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3*DW-1:0]   in_hsv,
  input  logic              in_bypass,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3*DW-1:0]   out_rgb,
  output logic [TAG_W-1:0]  out_tag
);

  localparam logic [DW-1:0] Max = '1;

  // Zero-extended DW x DW multiply, full 2*DW-bit result.
  function automatic logic [2*DW-1:0] mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    mul = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
  endfunction

  logic en;

  // Stage 1 registers
  logic              v1_q;
  logic [3*DW-1:0]   hsv1_q;
  logic [2:0]        sec1_q;
  logic [DW-1:0]     frac1_q;
  logic              byp1_q;
  logic [TAG_W-1:0]  tag1_q;

  // Stage 2 registers
  logic              v2_q;
  logic [3*DW-1:0]   hsv2_q;
  logic [2:0]        sec2_q;
  logic [DW-1:0]     p2_q, q2_q, t2_q;
  logic              byp2_q;
  logic [TAG_W-1:0]  tag2_q;

  // Stage 3 (output) registers
  logic              v3_q;
  logic [3*DW-1:0]   rgb_q;
  logic [TAG_W-1:0]  tag_q;

  // Stage 1 combinational: hue scaling
  logic [DW+2:0]     hs;
  logic [2:0]        sec_d;
  logic [DW-1:0]     frac_d;

  // Stage 2 combinational: products
  logic [DW-1:0]     sat1, val1;
  logic [2*DW-1:0]   p_full, sf_full, q_full, sfc_full, t_full;

  // Stage 3 combinational: channel select and packing
  logic [DW-1:0]     hue2, sat2, val2;
  logic [DW-1:0]     r_d, g_d, b_d;
  logic [3*DW-1:0]   rgb_d;

  // A bubble at the output may always be overwritten, so the pipe only stalls on a held pixel.
  always_comb begin
    en       = out_ready | ~v3_q;
    in_ready = en;
  end

  // Sector and fraction of the hue: H*6 split at bit DW.
  always_comb begin
    hs     = {3'b000, in_hsv[3*DW-1:2*DW]} * (DW+3)'(6);
    sec_d  = hs[DW+2:DW];
    frac_d = hs[DW-1:0];
  end

  // Truncating fixed-point P/Q/T from the stage-1 S, V and fraction.
  always_comb begin
    sat1     = hsv1_q[2*DW-1:DW];
    val1     = hsv1_q[DW-1:0];
    p_full   = mul(val1, Max - sat1);
    sf_full  = mul(sat1, frac1_q);
    q_full   = mul(val1, Max - sf_full[2*DW-1:DW]);
    sfc_full = mul(sat1, Max - frac1_q);
    t_full   = mul(val1, Max - sfc_full[2*DW-1:DW]);
  end

  // Pick R/G/B by sector, honouring bypass first and then the grey (S=0) case.
  always_comb begin
    hue2 = hsv2_q[3*DW-1:2*DW];
    sat2 = hsv2_q[2*DW-1:DW];
    val2 = hsv2_q[DW-1:0];
    r_d  = '0;
    g_d  = '0;
    b_d  = '0;
    if (byp2_q) begin
      r_d = hue2;
      g_d = sat2;
      b_d = val2;
    end else if (sat2 == '0) begin
      r_d = val2;
      g_d = val2;
      b_d = val2;
    end else begin
      case (sec2_q)
        3'd0: begin r_d = val2; g_d = t2_q; b_d = p2_q; end
        3'd1: begin r_d = q2_q; g_d = val2; b_d = p2_q; end
        3'd2: begin r_d = p2_q; g_d = val2; b_d = t2_q; end
        3'd3: begin r_d = p2_q; g_d = q2_q; b_d = val2; end
        3'd4: begin r_d = t2_q; g_d = p2_q; b_d = val2; end
        3'd5: begin r_d = val2; g_d = p2_q; b_d = q2_q; end
        default: begin r_d = '0; g_d = '0; b_d = '0; end
      endcase
    end
    if (ORDER == 1) begin
      rgb_d = {r_d, b_d, g_d};
    end else begin
      rgb_d = {r_d, g_d, b_d};
    end
  end

  // Stage valids and the visible output; reset drops every in-flight pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      rgb_q <= '0;
      tag_q <= '0;
    end else if (en) begin
      v1_q  <= in_valid;
      v2_q  <= v1_q;
      v3_q  <= v2_q;
      rgb_q <= rgb_d;
      tag_q <= tag2_q;
    end
  end

  // Internal data registers; contents behind a cleared valid are don't-care.
  always_ff @(posedge clk) begin
    if (en) begin
      hsv1_q  <= in_hsv;
      sec1_q  <= sec_d;
      frac1_q <= frac_d;
      byp1_q  <= in_bypass;
      tag1_q  <= in_tag;
      hsv2_q  <= hsv1_q;
      sec2_q  <= sec1_q;
      p2_q    <= p_full[2*DW-1:DW];
      q2_q    <= q_full[2*DW-1:DW];
      t2_q    <= t_full[2*DW-1:DW];
      byp2_q  <= byp1_q;
      tag2_q  <= tag1_q;
    end
  end

  // H < 2^DW keeps H*6 below 6*2^DW, so sectors 6 and 7 can never appear.
  always_ff @(posedge clk) begin
    if (rst_n && v1_q) begin
      assert (sec1_q <= 3'd5);
    end
  end

  always_comb begin
    out_valid = v3_q;
    out_rgb   = rgb_q;
    out_tag   = tag_q;
  end

endmodule
